// File: rtl/pack_pkg.sv
// pack_pkg: sizing helpers shared by the width-up packer and its output stage
package pack_pkg;
  function automatic int pack_ratio(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction
  function automatic int pack_cw(input int in_w, input int out_w);
    return $clog2(out_w / in_w) + 1;
  endfunction
  function automatic logic pack_ok(input int in_w, input int out_w);
    int r;
    r = out_w / in_w;
    return (out_w % in_w == 0) && (r >= 2) && ((r & (r - 1)) == 0);
  endfunction
endpackage

// File: rtl/pack_out_stage.sv
// pack_out_stage: output holding register that keeps a word until downstream takes it
module pack_out_stage #(
  parameter int W  = 128,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic [CW-1:0] load_count,
  input  logic          load_last,
  input  logic          ready,
  output logic          valid,
  output logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          last
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      count <= load_count;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pack_wr_stream.sv
// pack_wr_stream: packs narrow beats into wide words, flushing early on last_in, with one parked word
module pack_wr_stream
  import pack_pkg::*;
#(
  parameter int   IN_WIDTH  = 16,
  parameter int   OUT_WIDTH = 128,
  parameter logic MSB_FIRST = 1'b0
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    valid_in,
  output logic                                    ready_in,
  input  logic [IN_WIDTH-1:0]                     data_in,
  input  logic                                    last_in,
  output logic                                    valid_out,
  input  logic                                    ready_out,
  output logic [OUT_WIDTH-1:0]                    data_out,
  output logic [pack_cw(IN_WIDTH, OUT_WIDTH)-1:0] count_out,
  output logic                                    last_out
);
  localparam int RATIO = pack_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int CW    = pack_cw(IN_WIDTH, OUT_WIDTH);
  localparam int IW    = $clog2(RATIO);

  if (!pack_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
    $error("pack_wr_stream: OUT_WIDTH/IN_WIDTH must be a power of two >= 2");
  end

  logic [OUT_WIDTH-1:0] acc, word, load_data;
  logic [IW-1:0]        idx, slot;
  logic [CW-1:0]        pend_cnt, load_cnt;
  logic                 pend, pend_last, accept, complete, can_load, load, load_last;

  assign ready_in = !pend;

  // While a word is parked the accumulator holds it, so the output reloads from acc
  always_comb begin
    accept    = valid_in && !pend;
    slot      = MSB_FIRST ? IW'(RATIO - 1) - idx : idx;
    word      = acc | (OUT_WIDTH'(data_in) << (IN_WIDTH * int'(slot)));
    complete  = accept && (last_in || idx == IW'(RATIO - 1));
    can_load  = !valid_out || ready_out;
    load      = pend ? ready_out : complete && can_load;
    load_data = pend ? acc : word;
    load_cnt  = pend ? pend_cnt : CW'(idx) + CW'(1);
    load_last = pend ? pend_last : last_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc       <= '0;
      idx       <= '0;
      pend      <= 1'b0;
      pend_cnt  <= '0;
      pend_last <= 1'b0;
    end else if (pend) begin
      if (ready_out) begin
        pend <= 1'b0;
        acc  <= '0;
      end
    end else if (accept) begin
      acc       <= complete && can_load ? '0 : word;
      idx       <= complete ? '0 : idx + IW'(1);
      pend      <= complete && !can_load;
      pend_cnt  <= load_cnt;
      pend_last <= last_in;
    end
  end

  pack_out_stage #(.W(OUT_WIDTH), .CW(CW)) u_out (
    .clk        (clk_in),
    .rst        (rst_in),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_cnt),
    .load_last  (load_last),
    .ready      (ready_out),
    .valid      (valid_out),
    .data       (data_out),
    .count      (count_out),
    .last       (last_out)
  );
endmodule

// File: tb/tb_pack_wr_stream.sv
// tb_pack_wr_stream: scoreboard bench for the packer, directed 16/128 vectors plus 8/32 and 32/64 random sweeps
module tb_pack_wr_stream;
  typedef struct packed {
    logic [127:0] d;
    logic [7:0]   c;
    logic         l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1, rst_s = 1'b1;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  exp_t q0[$], q1[$], q2[$], q3[$];
  logic done2 = 1'b0, done3 = 1'b0;

  logic        vin = 1'b0, lin = 1'b0, rout = 1'b1;
  logic [15:0] din = '0;
  logic        rdy0, vo0, lo0, rdy1, vo1, lo1;
  logic [127:0] do0, do1;
  logic [3:0]  co0, co1;

  logic        v2 = 1'b0, l2 = 1'b0, ro2 = 1'b0, rdy2, vo2, lo2;
  logic [7:0]  d2 = '0;
  logic [31:0] do2;
  logic [2:0]  co2;
  logic        v3 = 1'b0, l3 = 1'b0, ro3 = 1'b0, rdy3, vo3, lo3;
  logic [31:0] d3 = '0;
  logic [63:0] do3;
  logic [1:0]  co3;

  pack_wr_stream #(.IN_WIDTH(16), .OUT_WIDTH(128), .MSB_FIRST(1'b0)) u0 (
    .clk_in(clk), .rst_in(rst), .valid_in(vin), .ready_in(rdy0), .data_in(din), .last_in(lin),
    .valid_out(vo0), .ready_out(rout), .data_out(do0), .count_out(co0), .last_out(lo0));
  pack_wr_stream #(.IN_WIDTH(16), .OUT_WIDTH(128), .MSB_FIRST(1'b1)) u1 (
    .clk_in(clk), .rst_in(rst), .valid_in(vin), .ready_in(rdy1), .data_in(din), .last_in(lin),
    .valid_out(vo1), .ready_out(rout), .data_out(do1), .count_out(co1), .last_out(lo1));
  pack_wr_stream #(.IN_WIDTH(8), .OUT_WIDTH(32), .MSB_FIRST(1'b0)) u2 (
    .clk_in(clk), .rst_in(rst_s), .valid_in(v2), .ready_in(rdy2), .data_in(d2), .last_in(l2),
    .valid_out(vo2), .ready_out(ro2), .data_out(do2), .count_out(co2), .last_out(lo2));
  pack_wr_stream #(.IN_WIDTH(32), .OUT_WIDTH(64), .MSB_FIRST(1'b0)) u3 (
    .clk_in(clk), .rst_in(rst_s), .valid_in(v3), .ready_in(rdy3), .data_in(d3), .last_in(l3),
    .valid_out(vo3), .ready_out(ro3), .data_out(do3), .count_out(co3), .last_out(lo3));

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s: got word expected none", n);
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    vin = 1'b1;
    din = d;
    lin = l;
    @(posedge clk); #1;
    vin = 1'b0;
    lin = 1'b0;
  endtask

  task automatic push(input logic [127:0] e0, input logic [127:0] e1, input int c, input logic l);
    q0.push_back('{e0, 8'(c), l});
    q1.push_back('{e1, 8'(c), l});
  endtask

  always @(negedge clk) begin : m0
    exp_t e;
    if (vo0 && rout) begin
      if (q0.size() == 0) fail("u0 unexpected");
      else begin
        e = q0.pop_front();
        chk("u0 data", do0, e.d);
        chk("u0 count", 128'(co0), 128'(e.c));
        chk("u0 last", 128'(lo0), 128'(e.l));
      end
    end
  end

  always @(negedge clk) begin : m1
    exp_t e;
    if (vo1 && rout) begin
      if (q1.size() == 0) fail("u1 unexpected");
      else begin
        e = q1.pop_front();
        chk("u1 data", do1, e.d);
        chk("u1 count", 128'(co1), 128'(e.c));
        chk("u1 last", 128'(lo1), 128'(e.l));
      end
    end
  end

  always @(negedge clk) begin : m2
    exp_t e;
    if (vo2 && ro2) begin
      if (q2.size() == 0) fail("u2 unexpected");
      else begin
        e = q2.pop_front();
        chk("u2 data", 128'(do2), e.d);
        chk("u2 count", 128'(co2), 128'(e.c));
        chk("u2 last", 128'(lo2), 128'(e.l));
      end
    end
  end

  always @(negedge clk) begin : m3
    exp_t e;
    if (vo3 && ro3) begin
      if (q3.size() == 0) fail("u3 unexpected");
      else begin
        e = q3.pop_front();
        chk("u3 data", 128'(do3), e.d);
        chk("u3 count", 128'(co3), 128'(e.c));
        chk("u3 last", 128'(lo3), 128'(e.l));
      end
    end
  end

  initial begin : sw2
    int n, idx;
    logic [63:0] w;
    n = 0; idx = 0; w = '0;
    wait (!rst_s);
    while (n < 1000) begin
      @(posedge clk); #1;
      v2 = $urandom_range(0, 9) < 7;
      d2 = 8'($urandom);
      l2 = (n == 999) || ($urandom_range(0, 7) == 0);
      ro2 = $urandom_range(0, 9) < 7;
      @(negedge clk);
      if (v2 && rdy2) begin
        w |= 64'(d2) << (idx * 8);
        if (idx == 3 || l2) begin
          q2.push_back('{128'(w), 8'(idx + 1), l2});
          w = '0;
          idx = 0;
        end else idx++;
        n++;
      end
    end
    @(posedge clk); #1;
    v2 = 1'b0; l2 = 1'b0; ro2 = 1'b1; done2 = 1'b1;
  end

  initial begin : sw3
    int n, idx;
    logic [63:0] w;
    n = 0; idx = 0; w = '0;
    wait (!rst_s);
    while (n < 1000) begin
      @(posedge clk); #1;
      v3 = $urandom_range(0, 9) < 6;
      d3 = $urandom;
      l3 = (n == 999) || ($urandom_range(0, 5) == 0);
      ro3 = $urandom_range(0, 9) < 6;
      @(negedge clk);
      if (v3 && rdy3) begin
        w |= 64'(d3) << (idx * 32);
        if (idx == 1 || l3) begin
          q3.push_back('{128'(w), 8'(idx + 1), l3});
          w = '0;
          idx = 0;
        end else idx++;
        n++;
      end
    end
    @(posedge clk); #1;
    v3 = 1'b0; l3 = 1'b0; ro3 = 1'b1; done3 = 1'b1;
  end

  initial begin : main
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_s = 1'b0;
    chk("rst ready_in", 128'(rdy0), 128'(1));
    chk("rst valid_out", 128'(vo0), 128'(0));
    chk("rst data_out", do0, 128'(0));
    chk("rst count_out", 128'(co0), 128'(0));
    chk("rst last_out", 128'(lo0), 128'(0));

    push(128'hBEEF_DEAD_3210_7654_5678_1234_DCBA_ABCD,
         128'hABCD_DCBA_1234_5678_7654_3210_DEAD_BEEF, 8, 1'b0);
    send(16'hABCD, 0); send(16'hDCBA, 0); send(16'h1234, 0); send(16'h5678, 0);
    send(16'h7654, 0); send(16'h3210, 0); send(16'hDEAD, 0);
    chk("valid before beat 8", 128'(vo0), 128'(0));
    send(16'hBEEF, 0);
    chk("valid after beat 8", 128'(vo0), 128'(1));
    repeat (2) @(posedge clk);
    #1;

    push(128'h3333_2222_1111, 128'h1111_2222_3333_0000_0000_0000_0000_0000, 3, 1'b1);
    push(128'h00AA, 128'h00AA_0000_0000_0000_0000_0000_0000_0000, 1, 1'b1);
    push(128'h8888_7777_6666_5555_4444_3333_2222_1111,
         128'h1111_2222_3333_4444_5555_6666_7777_8888, 8, 1'b1);
    send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 1);
    send(16'h00AA, 1);
    for (int i = 1; i <= 8; i++) send(16'(i * 16'h1111), i == 8);
    repeat (3) @(posedge clk);
    #1;

    push(128'h0107_0106_0105_0104_0103_0102_0101_0100,
         128'h0100_0101_0102_0103_0104_0105_0106_0107, 8, 1'b0);
    push(128'h010F_010E_010D_010C_010B_010A_0109_0108,
         128'h0108_0109_010A_010B_010C_010D_010E_010F, 8, 1'b0);
    rout = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("stall ready_in high", 128'(rdy0), 128'(1));
      send(16'h0100 + 16'(i), 0);
    end
    chk("stall ready_in low", 128'(rdy0), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("stall hold valid", 128'(vo0), 128'(1));
    chk("stall hold data", do0, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    chk("stall ready_in still low", 128'(rdy0), 128'(0));
    rout = 1'b1;
    @(posedge clk); #1;
    chk("ready_in after reload", 128'(rdy0), 128'(1));
    repeat (3) @(posedge clk);
    #1;

    for (int i = 1; i <= 5; i++) send(16'hE000 + 16'(i), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid rst valid_out", 128'(vo0), 128'(0));
    chk("mid rst ready_in", 128'(rdy0), 128'(1));
    push(128'h0008_0007_0006_0005_0004_0003_0002_0001,
         128'h0001_0002_0003_0004_0005_0006_0007_0008, 8, 1'b0);
    for (int i = 1; i <= 8; i++) send(16'(i), 0);

    for (int t = 0; t < 20000 && !(done2 && done3); t++) @(posedge clk);
    if (!(done2 && done3)) begin
      checks++;
      errors++;
      $display("FAIL sweep timeout: got done=%b%b expected 11", done2, done3);
    end
    repeat (10) @(posedge clk);
    #1;
    chk("u0 queue empty", 128'(q0.size()), 128'(0));
    chk("u1 queue empty", 128'(q1.size()), 128'(0));
    chk("u2 queue empty", 128'(q2.size()), 128'(0));
    chk("u3 queue empty", 128'(q3.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
